// File: rtl/riscv_defines.sv
// Shared RISC-V pipeline definitions: memory-access kinds, load/store funct3
// encodings, control/trap bundles carried down the pipe, the MEM pipeline
// register layout and the MEM-stage access FSM states.
package riscv_defines;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2
  } memaccess_t;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef struct packed {
    logic       regwrite;
    logic [1:0] resultsrc;
    memaccess_t memaccess;
    logic [2:0] funct3;
  } control_signal_t;

  typedef struct packed {
    logic        valid;
    logic [3:0]  cause;
    logic [31:0] tval;
  } trap_req_t;

  // MEM-stage access sequencing
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  // Contents of the EX/MEM pipeline register
  typedef struct packed {
    control_signal_t ctrl;
    logic [31:0]     aluresult;
    logic [31:0]     storedata;
    logic [31:0]     pcplus4;
    logic [4:0]      rd;
    trap_req_t       trap;
  } mem_reg_t;

  // An instruction touches data memory only if it is a load/store and is not
  // already carrying an exception.
  function automatic logic mem_access_enabled(input control_signal_t ctrl,
                                              input trap_req_t       trap);
    return (ctrl.memaccess != MEM_NONE) && !trap.valid;
  endfunction

endpackage

// File: rtl/stage_mem_if.sv
// Data-memory bus between the MEM stage (master) and data memory (slave).
//   dmem_req   : access request, held until dmem_ack
//   dmem_we    : 1 = write, 0 = read
//   dmem_addr  : word-aligned byte address
//   dmem_wdata : replicated store data
//   dmem_be    : byte enables (zero for reads)
//   dmem_rdata : raw read word from memory
//   dmem_ack   : completion; meaningful only while dmem_req=1
interface stage_mem_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/lsu_formatter.sv
// Purely combinational load/store lane formatter.
//   funct3     : load/store width and signedness
//   byte_off   : low two address bits
//   is_store   : store in progress -> drive wdata/be, else both zero
//   is_load    : load in progress  -> drive load_data, else zero
//   store_data : rs2 value from the pipeline
//   mem_rdata  : raw word returned by memory
//   wdata/be   : replicated store data and byte enables
//   load_data  : extracted, sign/zero-extended load result
module lsu_formatter
  import riscv_defines::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic        is_store,
  input  logic        is_load,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    wdata = '0;
    be    = '0;
    if (is_store) begin
      unique case (funct3)
        F3_SB: begin
          wdata = {4{store_data[7:0]}};
          be    = 4'b0001 << byte_off;
        end
        F3_SH: begin
          wdata = {2{store_data[15:0]}};
          be    = 4'b0011 << byte_off;
        end
        F3_SW: begin
          wdata = store_data;
          be    = '1;
        end
        default: begin
          wdata = '0;
          be    = '0;
        end
      endcase
    end
  end

  always_comb begin
    // Move the addressed byte/halfword down to bit 0 before extending
    shifted   = mem_rdata >> {byte_off, 3'b000};
    load_data = '0;
    if (is_load) begin
      unique case (funct3)
        F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
        F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
        F3_LW:   load_data = mem_rdata;
        F3_LBU:  load_data = {24'd0, shifted[7:0]};
        F3_LHU:  load_data = {16'd0, shifted[15:0]};
        default: load_data = '0;
      endcase
    end
  end

endmodule

// File: rtl/stage_mem.sv
// MEM pipeline stage: EX/MEM register, data-memory access sequencing with a
// variable-latency ack, and load/store formatting.
//   clk, rst          : clock, synchronous active-high reset
//   *_e               : instruction fields from execute
//   flush_m           : bubble the MEM register (ignored while stalled)
//   *_m               : registered copies for writeback
//   readdata_m        : formatted load data, valid in the ack cycle
//   busy_m            : stall request while an access is outstanding
//   dmem              : data-memory bus (master side)
module stage_mem
  import riscv_defines::*;
(
  input  logic            clk,
  input  logic            rst,
  input  control_signal_t control_signal_e,
  input  logic [31:0]     aluresult_e,
  input  logic [31:0]     storedata_e,
  input  logic [31:0]     pcplus4_e,
  input  logic [4:0]      rd_e,
  input  trap_req_t       trap_req_e,
  input  logic            flush_m,
  output control_signal_t control_signal_m,
  output logic [31:0]     aluresult_m,
  output logic [31:0]     pcplus4_m,
  output logic [4:0]      rd_m,
  output trap_req_t       trap_req_m,
  output logic [31:0]     readdata_m,
  output logic            busy_m,
  stage_mem_if.master     dmem
);

  mem_reg_t   mem_q, mem_d;
  mem_state_t state_q, state_d;

  logic        access_en;
  logic        req;
  logic        busy;
  logic        is_load;
  logic        is_store;
  logic [31:0] fmt_wdata;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_load;

  // Request/FSM. In IDLE the request goes out in the same cycle the
  // instruction lands in the MEM register; WAIT only exists while the ack
  // is late, so a same-cycle ack never stalls.
  always_comb begin
    access_en = mem_access_enabled(mem_q.ctrl, mem_q.trap);
    req       = 1'b0;
    state_d   = state_q;
    unique case (state_q)
      IDLE: begin
        req = access_en;
        if (access_en && !dmem.dmem_ack) state_d = WAIT;
      end
      WAIT: begin
        req = 1'b1;
        if (dmem.dmem_ack) state_d = IDLE;
      end
    endcase
    busy = req & ~dmem.dmem_ack;
  end

  // Pipeline register: hold while stalled (flush deferred), else bubble or capture
  always_comb begin
    mem_d = mem_q;
    if (!busy) begin
      if (flush_m) begin
        mem_d = '0;
      end else begin
        mem_d.ctrl      = control_signal_e;
        mem_d.aluresult = aluresult_e;
        mem_d.storedata = storedata_e;
        mem_d.pcplus4   = pcplus4_e;
        mem_d.rd        = rd_e;
        mem_d.trap      = trap_req_e;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '0;
      state_q <= IDLE;
    end else begin
      mem_q   <= mem_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    is_load  = (mem_q.ctrl.memaccess == MEM_READ);
    is_store = (mem_q.ctrl.memaccess == MEM_WRITE);
  end

  lsu_formatter u_lsu_formatter (
    .funct3     (mem_q.ctrl.funct3),
    .byte_off   (mem_q.aluresult[1:0]),
    .is_store   (is_store),
    .is_load    (is_load),
    .store_data (mem_q.storedata),
    .mem_rdata  (dmem.dmem_rdata),
    .wdata      (fmt_wdata),
    .be         (fmt_be),
    .load_data  (fmt_load)
  );

  // Bus outputs come straight from the held register, so they stay stable
  // for the whole WAIT period.
  always_comb begin
    dmem.dmem_req   = req;
    dmem.dmem_we    = is_store;
    dmem.dmem_addr  = {mem_q.aluresult[31:2], 2'b00};
    dmem.dmem_wdata = fmt_wdata;
    dmem.dmem_be    = fmt_be;
  end

  always_comb begin
    control_signal_m = mem_q.ctrl;
    aluresult_m      = mem_q.aluresult;
    pcplus4_m        = mem_q.pcplus4;
    rd_m             = mem_q.rd;
    trap_req_m       = mem_q.trap;
    readdata_m       = fmt_load;
    busy_m           = busy;
  end

endmodule
